// File: rtl/mips_step_ctrl.sv
// rtl/mips_step_ctrl.sv - board key/switch sequencer: debounced step, load and display control for the MIPS core
module mips_step_ctrl #(
   parameter int DB_CYCLES = 2,
   parameter int RUN_DIV   = 8,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [9:0]       SW,
   input  logic [3:0]       KEY,
   input  logic [31:0]      pc_in,
   input  logic [31:0]      rf_rdata,
   output logic             step_en,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic [4:0]       rf_raddr,
   output logic [9:0]       LEDR,
   output logic [CNT_W-1:0] step_count
);

   localparam int DB_W  = $clog2(DB_CYCLES + 1);
   localparam int RUN_W = $clog2(RUN_DIV);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_DIV - 1);

   typedef enum logic [1:0] {IDLE, STEP, LOAD} state_t;

   state_t            state_q, state_d;
   logic [3:0]        sync1_q, sync2_q;
   logic [3:0]        stable_q, stable_d;
   logic [DB_W-1:0]   db_cnt_q [4];
   logic [DB_W-1:0]   db_cnt_d [4];
   logic [3:0]        press_q, press_d;
   logic [3:0]        pending_q, pending_d;
   logic [3:0]        clr_mask, set_mask;
   logic [RUN_W-1:0]  run_ctr_q, run_ctr_d;
   logic              run_wrap;
   logic [4:0]        rf_waddr_q, rf_waddr_d;
   logic [31:0]       rf_wdata_q, rf_wdata_d;
   logic [1:0]        disp_sel_q, disp_sel_d;
   logic [1:0]        idx;
   logic [9:0]        ledr_q, ledr_d;
   logic [CNT_W-1:0]  step_count_q, step_count_d;
   logic              unused_ok;

   assign unused_ok = ^{pc_in[31:12], pc_in[1:0], rf_rdata[31:10]};

   // A key is accepted only after sync2 has disagreed with stable for DB_CYCLES edges
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         stable_d[i] = stable_q[i];
         db_cnt_d[i] = '0;
         press_d[i]  = 1'b0;
         if (sync2_q[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               stable_d[i] = sync2_q[i];
               press_d[i]  = ~sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      run_wrap  = SW[8] && (run_ctr_q == RUN_LAST);
      run_ctr_d = (!SW[8] || run_wrap) ? '0 : run_ctr_q + 1'b1;
      set_mask  = (press_q & {3'b111, ~SW[8]}) | {3'b000, run_wrap};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      clr_mask     = '0;
      idx          = 2'd0;
      rf_waddr_d   = rf_waddr_q;
      rf_wdata_d   = rf_wdata_q;
      disp_sel_d   = disp_sel_q;
      step_count_d = step_count_q;
      case (state_q)
         IDLE: begin
            if (pending_q[0]) begin
               state_d  = STEP;
               clr_mask = 4'b0001;
            end else if (|pending_q[3:1]) begin
               idx      = pending_q[1] ? 2'd1 : (pending_q[2] ? 2'd2 : 2'd3);
               clr_mask = 4'b0001 << idx;
               if (SW[9]) begin
                  state_d    = LOAD;
                  rf_waddr_d = {3'b000, idx};
                  rf_wdata_d = {24'b0, SW[7:0]};
               end else begin
                  disp_sel_d = idx;
               end
            end
         end
         STEP: begin
            state_d      = IDLE;
            step_count_d = step_count_q + 1'b1;
         end
         LOAD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // set after clear so a press landing on the serving edge is not lost
      pending_d = (pending_q & ~clr_mask) | set_mask;
      ledr_d    = (disp_sel_q == 2'd0) ? pc_in[11:2] : rf_rdata[9:0];
   end

   always_comb begin
      step_en    = (state_q == STEP);
      rf_we      = (state_q == LOAD);
      rf_waddr   = rf_waddr_q;
      rf_wdata   = rf_wdata_q;
      rf_raddr   = {3'b000, disp_sel_q};
      LEDR       = ledr_q;
      step_count = step_count_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= 4'b1111;
         sync2_q      <= 4'b1111;
         stable_q     <= 4'b1111;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
         press_q      <= '0;
         pending_q    <= '0;
         run_ctr_q    <= '0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
         disp_sel_q   <= '0;
         ledr_q       <= '0;
         step_count_q <= '0;
      end else begin
         sync1_q      <= KEY;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
         press_q      <= press_d;
         pending_q    <= pending_d;
         run_ctr_q    <= run_ctr_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
         disp_sel_q   <= disp_sel_d;
         ledr_q       <= ledr_d;
         step_count_q <= step_count_d;
      end
   end

endmodule

// File: tb/tb_mips_step_ctrl.sv
// tb/tb_mips_step_ctrl.sv - directed self-checking bench for mips_step_ctrl
module tb_mips_step_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  SW;
   logic [3:0]  KEY;
   logic [31:0] pc_in;
   logic [31:0] rf_rdata;
   logic        step_en;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  rf_raddr;
   logic [9:0]  LEDR;
   logic [15:0] step_count;

   int compared   = 0;
   int mismatched = 0;
   int step_pulses = 0;
   int we_pulses   = 0;
   int overlaps    = 0;
   int back2back   = 0;
   logic prev_step = 1'b0;
   logic prev_we   = 1'b0;
   int s0;

   mips_step_ctrl #(.DB_CYCLES(2), .RUN_DIV(8), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .SW         (SW),
      .KEY        (KEY),
      .pc_in      (pc_in),
      .rf_rdata   (rf_rdata),
      .step_en    (step_en),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .rf_raddr   (rf_raddr),
      .LEDR       (LEDR),
      .step_count (step_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (step_en === 1'b1) step_pulses++;
      if (rf_we === 1'b1) we_pulses++;
      if (step_en === 1'b1 && rf_we === 1'b1) overlaps++;
      if ((step_en === 1'b1 && prev_step) || (rf_we === 1'b1 && prev_we)) back2back++;
      prev_step = (step_en === 1'b1);
      prev_we   = (rf_we === 1'b1);
   end

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset    = 1'b1;
      SW       = 10'h000;
      KEY      = 4'b1111;
      pc_in    = 32'h0;
      rf_rdata = 32'h0;
      tick(2);
      reset = 1'b0;

      // reset state
      check("rst_step_en", step_en, 0);
      check("rst_rf_we", rf_we, 0);
      check("rst_rf_waddr", rf_waddr, 0);
      check("rst_rf_wdata", rf_wdata, 0);
      check("rst_rf_raddr", rf_raddr, 0);
      check("rst_ledr", LEDR, 0);
      check("rst_step_count", step_count, 0);
      tick(50);
      check("idle_no_step", step_pulses, 0);
      check("idle_no_we", we_pulses, 0);

      // load via KEY[1]
      SW  = 10'h205;
      KEY = 4'b1101;
      tick(2);
      KEY = 4'b1111;
      tick(3);
      check("load_not_early", rf_we, 0);
      tick(1);
      check("load_we", rf_we, 1);
      check("load_waddr", rf_waddr, 1);
      check("load_wdata", rf_wdata, 32'h5);
      check("load_no_step", step_en, 0);
      tick(1);
      check("load_we_drop", rf_we, 0);
      tick(10);
      check("load_one_pulse", we_pulses, 1);
      check("load_step_none", step_pulses, 0);

      // KEY[0]: glitch rejected, then two clean presses
      SW  = 10'h000;
      KEY = 4'b1110;
      tick(1);
      KEY = 4'b1111;
      tick(20);
      check("glitch_no_step", step_pulses, 0);
      KEY = 4'b1110;
      tick(2);
      KEY = 4'b1111;
      tick(3);
      check("step_not_early", step_en, 0);
      tick(1);
      check("step_pulse", step_en, 1);
      tick(10);
      KEY = 4'b1110;
      tick(2);
      KEY = 4'b1111;
      tick(10);
      check("step_two_pulses", step_pulses, 2);
      check("step_count_2", step_count, 2);

      // display select via KEY[2]
      pc_in    = 32'h0000_0ABC;
      rf_rdata = 32'h0000_03FF;
      KEY = 4'b1011;
      tick(2);
      KEY = 4'b1111;
      tick(3);
      check("disp_raddr_before", rf_raddr, 0);
      tick(1);
      check("disp_raddr", rf_raddr, 2);
      check("disp_ledr_pc", LEDR, 10'h2AF);
      tick(1);
      check("disp_ledr_rf", LEDR, 10'h3FF);
      tick(10);
      check("disp_no_we", we_pulses, 1);
      check("disp_no_step", step_pulses, 2);

      // simultaneous KEY[0] + KEY[3] in load mode
      SW  = 10'h2AA;
      KEY = 4'b0110;
      tick(2);
      KEY = 4'b1111;
      tick(4);
      check("dual_step", step_en, 1);
      check("dual_step_no_we", rf_we, 0);
      tick(1);
      check("dual_gap_step", step_en, 0);
      check("dual_gap_we", rf_we, 0);
      tick(1);
      check("dual_we", rf_we, 1);
      check("dual_waddr", rf_waddr, 3);
      check("dual_wdata", rf_wdata, 32'hAA);
      check("dual_we_no_step", step_en, 0);
      tick(10);
      check("dual_step_count", step_count, 3);

      // run mode for 40 cycles
      SW = 10'h100;
      s0 = step_pulses;
      tick(40);
      SW = 10'h000;
      tick(10);
      check("run_pulses", step_pulses - s0, 5);
      check("run_step_count", step_count, 8);

      // reset in the middle of a run with a tick pending
      SW = 10'h100;
      tick(8);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      SW    = 10'h000;
      check("mrst_step_count", step_count, 0);
      check("mrst_step_en", step_en, 0);
      check("mrst_ledr", LEDR, 0);
      tick(1);
      check("mrst_after_step_en", step_en, 0);
      check("mrst_after_ledr", LEDR, 10'h2AF);
      tick(1);
      check("mrst_after2_step_en", step_en, 0);
      tick(10);
      check("mrst_final_count", step_count, 0);

      check("never_overlap", overlaps, 0);
      check("never_back2back", back2back, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mips_step_ctrl.md
Name: mips_step_ctrl

Overview:
Board-facing sequencer for the single-cycle MIPS core in top_mips. It synchronises and debounces the active-low KEY buttons. It then turns key presses into one-cycle step enables for the PC and register file, and into register-file load writes from the SW switches. It also selects which value drives LEDR and provides a free-running auto-step mode.

Parameters:
DB_CYCLES, 2, consecutive cycles a synchronised key level must differ from the stable level before it is accepted (board builds override to ~500000)
RUN_DIV, 8, cycles between auto-step requests in run mode (minimum 2)
CNT_W, 16, width of step_count

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
SW  input  10  SW[9]=load mode, SW[8]=run mode, SW[7:0]=load data
KEY  input  4  active-low push buttons, asynchronous to clk
pc_in  input  32  current PC from core
rf_rdata  input  32  register-file read data for rf_raddr
step_en  output  1  one-cycle pulse: core commits exactly one instruction
rf_we  output  1  one-cycle register-file write strobe (load path)
rf_waddr  output  5  load destination register
rf_wdata  output  32  load data
rf_raddr  output  5  display read address, combinational {3'b0,disp_sel}
LEDR  output  10  registered display value
step_count  output  CNT_W  number of step_en pulses since reset

Behaviour:
- Reset (sync, high): sync/stable key regs <= 4'b1111; debounce counters, pending[3:0], run_ctr <= 0; state <= IDLE; step_en, rf_we <= 0; rf_waddr <= 0; rf_wdata <= 0; disp_sel <= 0; LEDR <= 0; step_count <= 0.
- Sync: 2-flop synchroniser per KEY bit.
- Debounce, per key: counter increments while sync2 != stable and clears otherwise. On the edge where the counter would reach DB_CYCLES: stable <= sync2, counter <= 0. If the new stable value is 0, press[i] pulses for one cycle. Release events are not reported.
- A key held low across reset deassertion yields exactly one press after DB_CYCLES.
- press[i] sets pending[i] on the next edge. A press on an already-pending key is absorbed (no queue depth >1).
- Run tick: when SW[8]=1, run_ctr counts 0..RUN_DIV-1; at wrap it sets pending[0]. run_ctr is held at 0 while SW[8]=0.
- KEY[0] presses are ignored (not latched) while SW[8]=1.
- FSM states IDLE, STEP, LOAD. IDLE serves the lowest-index pending bit only, clears it, and leaves the others pending.
  - pending[0] -> STEP.
  - pending[i], i=1..3, SW[9]=1 -> LOAD with rf_waddr<=i, rf_wdata<={24'b0,SW[7:0]} (SW sampled at this edge).
  - pending[i], i=1..3, SW[9]=0 -> disp_sel<=i, stay IDLE.
- STEP: step_en=1 for exactly this cycle, step_count += 1 (wraps modulo 2^CNT_W), then -> IDLE.
- LOAD: rf_we=1 for exactly this cycle, then -> IDLE. rf_waddr/rf_wdata hold their values until the next LOAD.
- step_en and rf_we are never both high, and neither is high two cycles in a row.
- Latency: KEY sampled low at edge 0 → press at edge DB_CYCLES+1 → pending at edge DB_CYCLES+2 → step_en/rf_we high during the cycle after edge DB_CYCLES+3.
- LEDR: registered every cycle. disp_sel=0 -> pc_in[11:2]; else rf_rdata[9:0].

Test Plan:
1. Reset 2 cycles, KEY=1111 → all outputs 0, LEDR=pc_in[11:2]=0; no pulses for 50 cycles.
2. SW=10'h205, KEY[1] low 2 cycles → one rf_we pulse, rf_waddr=1, rf_wdata=32'h5, timing per the latency rule; no step_en.
3. SW=0, KEY[0] low for 1 cycle → no event. Then KEY[0] low 2 cycles, twice, separated by 10 cycles → exactly 2 step_en pulses, step_count=2.
4. SW=0, KEY[2] press with rf_rdata=32'h3FF → rf_raddr=2, LEDR=10'h3FF one cycle after disp_sel updates; no rf_we/step_en.
5. KEY[0] and KEY[3] pressed simultaneously with SW[9]=1 → STEP in cycle n, LOAD to reg3 in cycle n+2; never overlapping.
6. SW[8]=1 for 40 cycles, RUN_DIV=8 → 5 step_en pulses. Assert reset mid-run → step_count=0, pending cleared, no pulse in the cycle after reset.
